// File: rtl/audio_pkg.sv
// Shared audio types and the saturating 16-bit mixer helper.
// Used by the I2S transmitter and by any other sample mixers on the core.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int FRAME_BITS = 32;
  localparam int SLOT_BITS  = 16;

  // Clamp a 17-bit signed sum back into sample_t range.
  function automatic sample_t sat_add16(input logic signed [16:0] sum);
    sample_t res;
    if (sum[16] == sum[15]) begin
      res = sample_t'(sum[15:0]);
    end else if (sum[16]) begin
      res = 16'sh8000;
    end else begin
      res = 16'sh7FFF;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample strobe bus from the core plus the I2S pin bundle toward the amplifier.
// master = core side (drives samples), slave = transmitter (drives pins).
interface audio_i2s_tx_if;
  import audio_pkg::*;

  logic    sample_stb;
  sample_t audio_l;
  sample_t audio_r;
  logic    i2s_bck;
  logic    i2s_ws;
  logic    i2s_din;
  logic    frame_req;
  logic    underrun;

  modport master (
    output sample_stb, audio_l, audio_r,
    input  i2s_bck, i2s_ws, i2s_din, frame_req, underrun
  );

  modport slave (
    input  sample_stb, audio_l, audio_r,
    output i2s_bck, i2s_ws, i2s_din, frame_req, underrun
  );

endinterface

// File: rtl/audio_i2s_tx_bck_gen.sv
// BCK divider: toggles i2s_bck every HALF_DIV clk32 cycles; fall_evt marks the 1->0 edge.
// Latency: first rise HALF_DIV cycles after en, first fall 2*HALF_DIV; no backpressure.
module i2s_bck_gen #(
  parameter int HALF_DIV = 20
) (
  input  logic clk32,
  input  logic reset_n,
  input  logic en,
  output logic i2s_bck,
  output logic fall_evt
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == CW'(HALF_DIV - 1));
  // Combinational so the data registers update on the same edge BCK falls.
  assign fall_evt = en & wrap & i2s_bck;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      i2s_bck <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      i2s_bck <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      i2s_bck <= ~i2s_bck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo/mono sample capture and Philips-I2S serialiser, 32-bit frames, 16-bit slots.
// Latency: capture 1 clk32, data at next frame load; no backpressure (underrun pulses instead).
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int HALF_DIV    = 20,
  parameter bit MONO        = 1'b1,
  parameter bit IN_UNSIGNED = 1'b1
) (
  input  logic           clk32,
  input  logic           reset_n,
  input  logic           en,
  audio_i2s_tx_if.slave  aud
);

  localparam sample_t IN_FLIP = IN_UNSIGNED ? 16'sh8000 : 16'sh0000;

  sample_t           in_l, in_r;
  sample_t           cap_l, cap_r;
  sample_t           hold_l, hold_r;
  sample_t           shift_l, shift_r;
  sample_t           load_l, load_r;
  sample_t           cur_l, cur_r;
  logic signed [16:0] mix_sum;
  logic              fresh;
  logic [4:0]        bit_cnt, bit_nxt;
  logic [3:0]        bit_idx;
  logic              load;
  logic              din_nxt, ws_nxt;
  logic              bck, fall_evt;
  logic              ws_q, din_q, frame_req_q, underrun_q;

  i2s_bck_gen #(.HALF_DIV(HALF_DIV)) u_bck_gen (
    .clk32    (clk32),
    .reset_n  (reset_n),
    .en       (en),
    .i2s_bck  (bck),
    .fall_evt (fall_evt)
  );

  always_comb begin
    in_l    = aud.audio_l ^ IN_FLIP;
    in_r    = aud.audio_r ^ IN_FLIP;
    mix_sum = {in_l[15], in_l} + {in_r[15], in_r};
    if (MONO) begin
      cap_l = sat_add16(mix_sum);
      cap_r = cap_l;
    end else begin
      cap_l = in_l;
      cap_r = in_r;
    end
    // A strobe coinciding with the load bypasses the hold register.
    load_l  = aud.sample_stb ? cap_l : hold_l;
    load_r  = aud.sample_stb ? cap_r : hold_r;
    bit_nxt = bit_cnt + 5'd1;
    load    = fall_evt && (bit_nxt == 5'd0);
    cur_l   = load ? load_l : shift_l;
    cur_r   = load ? load_r : shift_r;
    // Both slots are MSB first, so the in-slot index is 15 - low nibble.
    bit_idx = ~bit_nxt[3:0];
    din_nxt = bit_nxt[4] ? cur_r[bit_idx] : cur_l[bit_idx];
    ws_nxt  = (bit_nxt != 5'(FRAME_BITS - 1)) && (bit_nxt >= 5'(SLOT_BITS - 1));
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      hold_l      <= '0;
      hold_r      <= '0;
      fresh       <= 1'b0;
      shift_l     <= '0;
      shift_r     <= '0;
      bit_cnt     <= 5'(FRAME_BITS - 1);
      ws_q        <= 1'b0;
      din_q       <= 1'b0;
      frame_req_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      frame_req_q <= 1'b0;
      underrun_q  <= 1'b0;
      if (aud.sample_stb) begin
        hold_l <= cap_l;
        hold_r <= cap_r;
        fresh  <= 1'b1;
      end
      if (load) begin
        shift_l     <= load_l;
        shift_r     <= load_r;
        frame_req_q <= 1'b1;
        underrun_q  <= !fresh && !aud.sample_stb;
        fresh       <= 1'b0;
      end
      // en low drops the frame in flight but keeps the captured sample.
      if (!en) begin
        shift_l <= '0;
        shift_r <= '0;
        bit_cnt <= 5'(FRAME_BITS - 1);
        ws_q    <= 1'b0;
        din_q   <= 1'b0;
      end else if (fall_evt) begin
        bit_cnt <= bit_nxt;
        ws_q    <= ws_nxt;
        din_q   <= din_nxt;
      end
    end
  end

  assign aud.i2s_bck   = bck;
  assign aud.i2s_ws    = ws_q;
  assign aud.i2s_din   = din_q;
  assign aud.frame_req = frame_req_q;
  assign aud.underrun  = underrun_q;

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Audio output stage between the core's 16-bit stereo sample outputs and the board's I2S amplifier pins (hp_bck/hp_ws/hp_din).
- Captures strobed stereo samples into a one-deep holding register and optionally mixes them to mono with saturation.
- Generates BCK from clk32 with an integer divider and serialises 32-bit Philips-I2S frames.
- Replaces ad-hoc top-level I2S logic in all board variants.

## Interface
- HALF_DIV, 20, clk32 cycles per BCK half period; must be ≥2. Default gives BCK 800 kHz, fs 25 kHz.
- MONO, 1, 1: both slots carry sat(L+R); 0: L in left slot, R in right slot.
- IN_UNSIGNED, 1, 1: inputs are offset-binary (0x8000 = silence) and have their MSB inverted on capture; 0: inputs are two's complement.
- clk32  in  1  system clock, 32 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; top drives !por.
- sample_stb  in  1  one-cycle strobe; audio_l/audio_r are valid in this cycle.
- audio_l  in  16  left sample.
- audio_r  in  16  right sample.
- i2s_bck  out  1  bit clock.
- i2s_ws  out  1  word select; 0 = left, 1 = right.
- i2s_din  out  1  serial data, MSB first, two's complement.
- frame_req  out  1  one-cycle pulse when a frame loads.
- underrun  out  1  one-cycle pulse when a frame loads without a fresh sample.

## Operation
- **Capture:** on sample_stb, convert the inputs (MSB inversion if IN_UNSIGNED), then form the slot values:
  - MONO=1: 17-bit signed sum L+R, clamped to 0x7FFF / 0x8000; the result goes to both hold_l and hold_r.
  - MONO=0: hold_l = L, hold_r = R.
  - Set the fresh flag.
- **Divider:** counter 0..HALF_DIV-1. On wrap, toggle i2s_bck. A 1→0 toggle is a "fall event".
- **Bit counter:** bit_cnt, mod 32, advances on each fall event.
- **Frame load:** occurs on the fall event where bit_cnt becomes 0.
  - shift_l ← hold_l, shift_r ← hold_r.
  - Pulse frame_req.
  - If fresh=0, pulse underrun and reuse the previous hold values. Otherwise clear fresh.
- **Outputs:** registered and updated only on fall events, using the new bit_cnt:
  - i2s_din = shift_l[15-bit_cnt] for bit_cnt 0..15; shift_r[31-bit_cnt] for 16..31. The load's own fall event already outputs the new shift_l[15].
  - i2s_ws = bit_cnt_next[4], where bit_cnt_next = (bit_cnt+1) mod 32. WS therefore leads each slot's MSB by one BCK (Philips).
  - Bits 0..15 of a slot carry data; a 16-bit slot fills exactly 16 BCK, so there is no padding.
- **en low:** synchronously return the divider, bit_cnt and outputs to reset values. Hold registers and fresh keep their state, and capture continues.

## Timing
- **Reset values:** i2s_bck=0, i2s_ws=0, i2s_din=0, frame_req=0, underrun=0, bit_cnt=31, divider=0, hold_*=0, shift_*=0, fresh=0.
- **After en rises:**
  - First BCK rise is HALF_DIV cycles later.
  - First fall event is 2·HALF_DIV cycles later. It loads a frame, sets bit_cnt=0 and outputs left MSB.
  - The frame period is 64·HALF_DIV clk32 cycles.
- **sample_stb in the same cycle as a frame load:** the frame takes the new strobed values (bypass), and fresh ends cleared.
- **Two strobes between loads:** the last one wins. This is not flagged.
- Capture latency into hold is 1 clk32.
- Serial output latency is from the next frame load to the MSB at that fall edge.
- **reset_n asserted mid-frame:** all state returns to reset values immediately; the partial frame is dropped.
- **en falling mid-frame:** same as reset, except hold and fresh are preserved.
- Data and WS change only on BCK falling edges, so the receiver samples on rising edges with HALF_DIV clk32 cycles of setup.

## Structure
- Shared package audio_pkg:
  - typedef sample_t (logic signed [15:0]);
  - constants FRAME_BITS=32 and SLOT_BITS=16;
  - function sat_add16 (17-bit sum → clamped sample_t), reused by other mixers.
- Sub-module i2s_bck_gen (parameter HALF_DIV): divider, i2s_bck register and the fall-event pulse.
- The remaining logic (capture, frame counter, shifters) lives in audio_i2s_tx.

## Test plan
- **Reset / en release:** with reset_n low and en high, all outputs are 0. Release reset_n. The first BCK rise comes at 20 cycles and the first fall at 40. frame_req pulses at cycle 40, and underrun pulses with it (no sample yet).
- **Stereo serialisation:** MONO=0, IN_UNSIGNED=0. Strobe L=0xA55A, R=0x1234 before a load. Sampled on BCK rises: left slot A55A MSB-first, right slot 1234. WS rises one BCK before the R MSB and falls one BCK before the next L MSB.
- **Saturating mono:** MONO=1, IN_UNSIGNED=0.
  - L=0x7000, R=0x7000 → both slots 0x7FFF.
  - L=0x9000, R=0x9000 → 0x8000.
  - L=0x0100, R=0xFF00 → 0x0000.
- **Unsigned conversion:** IN_UNSIGNED=1, MONO=0, inputs 0x8000/0xFFFF → slots 0x0000/0x7FFF.
- **Strobe collision and underrun:** strobe L=0x1111 in the exact frame-load cycle → that frame carries 0x1111 with no underrun pulse. With no strobe before the next load → 0x1111 repeats and underrun pulses once.
- **Mid-frame abort:** drop en at bit_cnt=7 → BCK/WS/DIN are 0 the next cycle. Re-raise en → a fresh frame starts at bit 0 with the current hold values.
